// File: rtl/writeback_unit.sv
// Writeback stage: selects ALU/load/return-address data and drives a registered register-file write strobe.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_unit #(
  parameter logic [3:0]  RA_REG = 4'd15,
  parameter logic [31:0] PC_INC = 32'd4
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic [31:0] aluResult,
  input  logic        isLd,
  input  logic        isCall,
  input  logic        isWb,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        isWa,
  output logic [3:0]  wa,
  output logic [31:0] wd
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  rd_q, rd_d;
  logic        we_q, we_d;
  logic [3:0]  wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic        retire_s;
  logic        transfer_s;
  logic [3:0]  rd_s;
  logic        unused_inst_s;

  assign rd_s          = inst[25:22];
  assign unused_inst_s = ^{inst[31:26], inst[21:0]};
  assign in_ready      = (state_q == IDLE);
  assign transfer_s    = in_valid && (state_q == IDLE);

  // Next-state, write-port selection and retire detection
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    retire_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (transfer_s) begin
          if (!isWb) begin
            retire_s = 1'b1;
          end else if (isCall) begin
            we_d     = 1'b1;
            wa_d     = RA_REG;
            wd_d     = pc + PC_INC;
            retire_s = 1'b1;
          end else if (isLd) begin
            if (ld_valid) begin
              we_d     = 1'b1;
              wa_d     = rd_s;
              wd_d     = ld_data;
              retire_s = 1'b1;
            end else begin
              rd_d    = rd_s;
              state_d = WAIT_LD;
            end
          end else begin
            we_d     = 1'b1;
            wa_d     = rd_s;
            wd_d     = aluResult;
            retire_s = 1'b1;
          end
        end else begin
          retire_s = 1'b0;
        end
      end
      WAIT_LD: begin
        if (ld_valid) begin
          we_d     = 1'b1;
          wa_d     = rd_q;
          wd_d     = ld_data;
          retire_s = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = WAIT_LD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and write-port registers; reset discards any pending load
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      rd_q    <= 4'd0;
      we_q    <= 1'b0;
      wa_q    <= 4'd0;
      wd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  assign isWa = we_q;
  assign wa   = wa_q;
  assign wd   = wd_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired_q, retired_d;

  assign retired_d = retire_s ? (retired_q + 32'd1) : retired_q;

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (Reset) begin
      retired_q <= 32'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`else
  logic unused_retire_s;
  assign unused_retire_s = retire_s;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: vector table plus hand-written multi-cycle sequences.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] aluResult;
  logic        isLd;
  logic        isCall;
  logic        isWb;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        isWa;
  logic [3:0]  wa;
  logic [31:0] wd;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  writeback_unit dut (
    .clk(clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .inst(inst), .aluResult(aluResult), .isLd(isLd), .isCall(isCall),
    .isWb(isWb), .ld_valid(ld_valid), .ld_data(ld_data),
    .isWa(isWa), .wa(wa), .wd(wd)
`ifdef WB_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  wa;
    logic [31:0] wd;
  } wr_t;

  typedef struct {
    logic        is_ld;
    logic        is_call;
    logic        is_wb;
    logic [3:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        ld_v;
    logic [31:0] ld_d;
    logic        exp_we;
    logic [3:0]  exp_wa;
    logic [31:0] exp_wd;
  } vec_t;

  wr_t         sb_q[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [3:0]  last_wa;
  logic [31:0] last_wd;
  logic [31:0] exp_ret;
  vec_t        vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_ret(input string name);
`ifdef WB_RETIRE_CNT_EN
    chk(name, retired, exp_ret);
`else
    exp_ret = exp_ret;
`endif
  endtask

  // Advance one clock and check any write strobe against the scoreboard.
  task automatic tick();
    wr_t item;
    @(posedge clk);
    #1;
    if (isWa === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_write: got wa=%0d wd=0x%08h, expected no write", wa, wd);
      end else begin
        item = sb_q.pop_front();
        chk("sb_wa", {28'd0, wa}, {28'd0, item.wa});
        chk("sb_wd", wd, item.wd);
      end
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [3:0] rd);
    return {6'h2A, rd, 22'h15555};
  endfunction

  task automatic drive(input logic ld, input logic call, input logic wb, input logic [3:0] rd,
                       input logic [31:0] p, input logic [31:0] alu);
    in_valid  = 1'b1;
    isLd      = ld;
    isCall    = call;
    isWb      = wb;
    inst      = mk_inst(rd);
    pc        = p;
    aluResult = alu;
  endtask

  task automatic push(input logic [3:0] a, input logic [31:0] d);
    wr_t item;
    item.wa = a;
    item.wd = d;
    sb_q.push_back(item);
  endtask

  initial begin
    Reset = 1'b1; in_valid = 1'b0; pc = 32'd0; inst = 32'd0; aluResult = 32'd0;
    isLd = 1'b0; isCall = 1'b0; isWb = 1'b0; ld_valid = 1'b0; ld_data = 32'd0;
    exp_ret = 32'd0;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 4'd4,  32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0,          1'b1, 4'd4,  32'h1234_5678};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 4'd3,  32'h1000_0000, 32'h1111_1111, 1'b0, 32'h0,          1'b1, 4'd15, 32'h1000_0004};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 4'd7,  32'h0000_0040, 32'h2222_2222, 1'b1, 32'hA5A5_A5A5, 1'b1, 4'd7,  32'hA5A5_A5A5};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 4'd2,  32'h0000_0044, 32'h3333_3333, 1'b0, 32'h0,          1'b0, 4'd0,  32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 4'd8,  32'hFFFF_FFFE, 32'h4444_4444, 1'b0, 32'h0,          1'b1, 4'd15, 32'h0000_0002};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 4'd0,  32'h0000_0048, 32'hDEAD_BEEF, 1'b0, 32'h0,          1'b1, 4'd0,  32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 4'd12, 32'h0000_004C, 32'h0BAD_F00D, 1'b1, 32'h5555_5555, 1'b1, 4'd12, 32'h0BAD_F00D};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 4'd9,  32'h0000_0050, 32'h6666_6666, 1'b0, 32'h0,          1'b0, 4'd0,  32'h0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 4'd1,  32'h0000_0054, 32'h7777_7777, 1'b0, 32'h0,          1'b0, 4'd0,  32'h0};

    // Reset state
    tick(); tick();
    Reset = 1'b0;
    tick();
    chk("rst_isWa", {31'd0, isWa}, 32'd0);
    chk("rst_wa", {28'd0, wa}, 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk_ret("rst_retired");
    last_wa = 4'd0;
    last_wd = 32'd0;

    // Single-transfer vectors
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].is_ld, vecs[i].is_call, vecs[i].is_wb, vecs[i].rd, vecs[i].pc, vecs[i].alu);
      ld_valid = vecs[i].ld_v;
      ld_data  = vecs[i].ld_d;
      if (vecs[i].exp_we) begin
        push(vecs[i].exp_wa, vecs[i].exp_wd);
        last_wa = vecs[i].exp_wa;
        last_wd = vecs[i].exp_wd;
      end
      exp_ret = exp_ret + 32'd1;
      tick();
      chk($sformatf("vec%0d_isWa", i), {31'd0, isWa}, {31'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d_wa", i), {28'd0, wa}, {28'd0, last_wa});
      chk($sformatf("vec%0d_wd", i), wd, last_wd);
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      chk_ret($sformatf("vec%0d_retired", i));
      in_valid = 1'b0; ld_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d_pulse_end", i), {31'd0, isWa}, 32'd0);
      chk($sformatf("vec%0d_hold_wa", i), {28'd0, wa}, {28'd0, last_wa});
      chk($sformatf("vec%0d_hold_wd", i), wd, last_wd);
    end

    // Stray ld_valid in IDLE is ignored
    ld_valid = 1'b1; ld_data = 32'h7E7E_7E7E;
    tick();
    chk("stray_ld_isWa", {31'd0, isWa}, 32'd0);
    chk("stray_ld_in_ready", {31'd0, in_ready}, 32'd1);
    ld_valid = 1'b0;

    // Delayed load with a stalled ALU instruction behind it
    drive(1'b1, 1'b0, 1'b1, 4'd5, 32'h0000_0100, 32'h0);
    tick();
    chk("dld_in_ready_drop", {31'd0, in_ready}, 32'd0);
    chk("dld_no_write", {31'd0, isWa}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 4'd9, 32'h0000_0104, 32'h9999_0000);
    tick();
    chk("dld_stall1", {31'd0, in_ready}, 32'd0);
    tick();
    chk("dld_stall2", {31'd0, in_ready}, 32'd0);
    chk("dld_stall_no_write", {31'd0, isWa}, 32'd0);
    ld_valid = 1'b1; ld_data = 32'hCAFE_BABE;
    push(4'd5, 32'hCAFE_BABE);
    exp_ret = exp_ret + 32'd1;
    tick();
    chk("dld_isWa", {31'd0, isWa}, 32'd1);
    chk("dld_wa", {28'd0, wa}, 32'd5);
    chk("dld_wd", wd, 32'hCAFE_BABE);
    chk("dld_in_ready_back", {31'd0, in_ready}, 32'd1);
    chk_ret("dld_retired");
    ld_valid = 1'b0;
    push(4'd9, 32'h9999_0000);
    exp_ret = exp_ret + 32'd1;
    tick();
    chk("stalled_isWa", {31'd0, isWa}, 32'd1);
    chk("stalled_wa", {28'd0, wa}, 32'd9);
    in_valid = 1'b0;
    tick();
    chk("stalled_pulse_end", {31'd0, isWa}, 32'd0);

    // Reset wins over a same-cycle transfer
    Reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 4'd10, 32'h0, 32'h1010_1010);
    exp_ret = 32'd0;
    tick();
    Reset = 1'b0; in_valid = 1'b0;
    tick();
    chk("rstprio_isWa", {31'd0, isWa}, 32'd0);
    chk("rstprio_wa", {28'd0, wa}, 32'd0);
    chk("rstprio_wd", wd, 32'd0);
    chk_ret("rstprio_retired");

    // Back-to-back ALU writes to r1..r3
    for (int r = 1; r <= 3; r++) begin
      drive(1'b0, 1'b0, 1'b1, r[3:0], 32'h0, 32'hB000_0000 + r);
      push(r[3:0], 32'hB000_0000 + r);
      exp_ret = exp_ret + 32'd1;
      tick();
      chk($sformatf("b2b%0d_isWa", r), {31'd0, isWa}, 32'd1);
      chk($sformatf("b2b%0d_wa", r), {28'd0, wa}, r);
      chk($sformatf("b2b%0d_wd", r), wd, 32'hB000_0000 + r);
    end
    chk_ret("b2b_retired");
    in_valid = 1'b0;
    tick();
    chk("b2b_pulse_end", {31'd0, isWa}, 32'd0);

    // Reset while waiting for a load discards it
    drive(1'b1, 1'b0, 1'b1, 4'd6, 32'h0, 32'h0);
    tick();
    chk("rstwait_in_wait", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    Reset = 1'b1;
    exp_ret = 32'd0;
    tick();
    Reset = 1'b0;
    ld_valid = 1'b1; ld_data = 32'h1357_9BDF;
    tick();
    ld_valid = 1'b0;
    tick();
    chk("rstwait_isWa", {31'd0, isWa}, 32'd0);
    chk("rstwait_wa", {28'd0, wa}, 32'd0);
    chk("rstwait_wd", wd, 32'd0);
    chk("rstwait_in_ready", {31'd0, in_ready}, 32'd1);
    chk_ret("rstwait_retired");

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
